// File: rtl/regfile_read_bypass.sv
// Operand read stage behind the dual-read register file. It merges a write issued in the same cycle into the late read data.
// Optional REGFILE_BYPASS_ZERO_REG_EN makes address 0 a hardwired zero register.
module regfile_read_bypass #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  iReadValid,
   input  logic [ADDR_WIDTH-1:0] iReadAddress0,
   input  logic [ADDR_WIDTH-1:0] iReadAddress1,
   input  logic                  iWriteEnable,
   input  logic [ADDR_WIDTH-1:0] iWriteAddress,
   input  logic [DATA_WIDTH-1:0] iWriteData,
   input  logic [DATA_WIDTH-1:0] iRamData0,
   input  logic [DATA_WIDTH-1:0] iRamData1,
   input  logic                  iClearCount,
   output logic                  oValid,
   output logic [DATA_WIDTH-1:0] oData0,
   output logic [DATA_WIDTH-1:0] oData1,
   output logic                  oHit0,
   output logic                  oHit1,
   output logic [CNT_WIDTH-1:0]  oBypassCount
);

   logic                  rd_vld_q,   rd_vld_d;
   logic [ADDR_WIDTH-1:0] rd_addr0_q, rd_addr0_d;
   logic [ADDR_WIDTH-1:0] rd_addr1_q, rd_addr1_d;
   logic                  wr_en_q,    wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;

   logic                  out_vld_q,   out_vld_d;
   logic [DATA_WIDTH-1:0] out_data0_q, out_data0_d;
   logic [DATA_WIDTH-1:0] out_data1_q, out_data1_d;
   logic                  out_hit0_q,  out_hit0_d;
   logic                  out_hit1_q,  out_hit1_d;
   logic [CNT_WIDTH-1:0]  byp_cnt_q,   byp_cnt_d;

   logic                  zero0, zero1;
   logic                  hit0, hit1;
   logic [1:0]            hit_inc;
   logic [CNT_WIDTH:0]    cnt_sum;

`ifdef REGFILE_BYPASS_ZERO_REG_EN
   assign zero0 = (rd_addr0_q == '0);
   assign zero1 = (rd_addr1_q == '0);
`else
   assign zero0 = 1'b0;
   assign zero1 = 1'b0;
`endif

   // Register file returns pre-write data for a same-cycle write; the captured write wins.
   assign hit0 = wr_en_q & (wr_addr_q == rd_addr0_q) & ~zero0;
   assign hit1 = wr_en_q & (wr_addr_q == rd_addr1_q) & ~zero1;

   always_comb begin
      rd_vld_d   = iReadValid;
      rd_addr0_d = iReadAddress0;
      rd_addr1_d = iReadAddress1;
      wr_en_d    = iWriteEnable;
      wr_addr_d  = iWriteAddress;
      wr_data_d  = iWriteData;
   end

   always_comb begin
      out_vld_d   = rd_vld_q;
      out_data0_d = out_data0_q;
      out_data1_d = out_data1_q;
      out_hit0_d  = hit0 & rd_vld_q;
      out_hit1_d  = hit1 & rd_vld_q;
      if (rd_vld_q) begin
         if (zero0)     out_data0_d = '0;
         else if (hit0) out_data0_d = wr_data_q;
         else           out_data0_d = iRamData0;
         if (zero1)     out_data1_d = '0;
         else if (hit1) out_data1_d = wr_data_q;
         else           out_data1_d = iRamData1;
      end
   end

   // Counter accumulates the hit flags already presented on the outputs.
   always_comb begin
      hit_inc   = {1'b0, out_hit0_q} + {1'b0, out_hit1_q};
      cnt_sum   = {1'b0, byp_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, hit_inc};
      byp_cnt_d = byp_cnt_q;
      if (iClearCount)          byp_cnt_d = '0;
      else if (cnt_sum[CNT_WIDTH]) byp_cnt_d = '1;
      else                      byp_cnt_d = cnt_sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_vld_q    <= 1'b0;
         rd_addr0_q  <= '0;
         rd_addr1_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         out_vld_q   <= 1'b0;
         out_data0_q <= '0;
         out_data1_q <= '0;
         out_hit0_q  <= 1'b0;
         out_hit1_q  <= 1'b0;
         byp_cnt_q   <= '0;
      end else begin
         rd_vld_q    <= rd_vld_d;
         rd_addr0_q  <= rd_addr0_d;
         rd_addr1_q  <= rd_addr1_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         out_vld_q   <= out_vld_d;
         out_data0_q <= out_data0_d;
         out_data1_q <= out_data1_d;
         out_hit0_q  <= out_hit0_d;
         out_hit1_q  <= out_hit1_d;
         byp_cnt_q   <= byp_cnt_d;
      end
   end

   assign oValid       = out_vld_q;
   assign oData0       = out_data0_q;
   assign oData1       = out_data1_q;
   assign oHit0        = out_hit0_q;
   assign oHit1        = out_hit1_q;
   assign oBypassCount = byp_cnt_q;

endmodule

// File: tb/tb_regfile_read_bypass.sv
// Bench for regfile_read_bypass: a read-first register file model feeds the DUT.
// The expected operands come from the architectural register state at request time.
module tb_regfile_read_bypass;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int CW = 4;

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b0;
   logic          iReadValid = 1'b0;
   logic [AW-1:0] iReadAddress0 = '0, iReadAddress1 = '0;
   logic          iWriteEnable = 1'b0;
   logic [AW-1:0] iWriteAddress = '0;
   logic [DW-1:0] iWriteData = '0;
   logic [DW-1:0] iRamData0, iRamData1;
   logic          iClearCount = 1'b0;
   logic          oValid, oHit0, oHit1;
   logic [DW-1:0] oData0, oData1;
   logic [CW-1:0] oBypassCount;

   regfile_read_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .iReadValid(iReadValid),
      .iReadAddress0(iReadAddress0), .iReadAddress1(iReadAddress1),
      .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress), .iWriteData(iWriteData),
      .iRamData0(iRamData0), .iRamData1(iRamData1), .iClearCount(iClearCount),
      .oValid(oValid), .oData0(oData0), .oData1(oData1), .oHit0(oHit0), .oHit1(oHit1),
      .oBypassCount(oBypassCount));

   always #5 Clock = ~Clock;

   // Register file: synchronous read-first, so a same-cycle write reads stale.
   logic [DW-1:0] ram [16];
   logic [DW-1:0] rd0 = '0, rd1 = '0;
   always @(posedge Clock) begin
      rd0 <= ram[iReadAddress0];
      rd1 <= ram[iReadAddress1];
      if (iWriteEnable) ram[iWriteAddress] <= iWriteData;
   end
   assign iRamData0 = rd0;
   assign iRamData1 = rd1;

   int checks = 0;
   int errors = 0;
   bit run_chk = 0;

   // Architectural register contents and the expected result of the request being driven.
   int arch [16];
   bit req_v, req_h0, req_h1, req_clr;
   int req_d0, req_d1;
   bit stg_v, stg_h0, stg_h1;
   int stg_d0, stg_d1;
   bit e_vld, e_h0, e_h1;
   int e_d0, e_d1, e_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic operand(input int a, input bit we, input int wa, input int wd,
                          output int d, output bit h);
`ifdef REGFILE_BYPASS_ZERO_REG_EN
      if (a == 0) begin d = 0; h = 0; return; end
`endif
      if (we && wa == a) begin d = wd; h = 1; end
      else begin d = arch[a]; h = 0; end
   endtask

   task automatic step(input bit rv, input int a0, input int a1, input bit we,
                       input int wa, input int wd, input bit clr);
      iReadValid = rv; iReadAddress0 = a0[AW-1:0]; iReadAddress1 = a1[AW-1:0];
      iWriteEnable = we; iWriteAddress = wa[AW-1:0]; iWriteData = wd[DW-1:0];
      iClearCount = clr;
      req_v = rv; req_clr = clr;
      operand(a0, we, wa, wd, req_d0, req_h0);
      operand(a1, we, wa, wd, req_d1, req_h1);
      if (we) arch[wa] = wd;
      @(posedge Clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Expected outputs: each request appears two edges after it is driven; the count trails the hits by one edge.
   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         stg_v = 0; stg_h0 = 0; stg_h1 = 0; stg_d0 = 0; stg_d1 = 0;
         e_vld = 0; e_h0 = 0; e_h1 = 0; e_d0 = 0; e_d1 = 0; e_cnt = 0;
      end else begin
         if (req_clr) e_cnt = 0;
         else e_cnt = (e_cnt + e_h0 + e_h1 > 15) ? 15 : e_cnt + e_h0 + e_h1;
         if (stg_v) begin
            e_vld = 1; e_d0 = stg_d0; e_d1 = stg_d1; e_h0 = stg_h0; e_h1 = stg_h1;
         end else begin
            e_vld = 0; e_h0 = 0; e_h1 = 0;
         end
         stg_v = req_v; stg_d0 = req_d0; stg_d1 = req_d1;
         stg_h0 = req_h0 & req_v; stg_h1 = req_h1 & req_v;
      end
   end

   always @(negedge Clock) begin
      if (run_chk && Reset_n) begin
         chk("valid", oValid, e_vld);
         chk("data0", oData0, e_d0[DW-1:0]);
         chk("data1", oData1, e_d1[DW-1:0]);
         chk("hit0", oHit0, e_h0);
         chk("hit1", oHit1, e_h1);
         chk("count", oBypassCount, e_cnt[CW-1:0]);
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) begin ram[i] = '0; arch[i] = 0; end
      req_v = 0; req_clr = 0; req_h0 = 0; req_h1 = 0; req_d0 = 0; req_d1 = 0;
      repeat (2) @(posedge Clock);
      #1 Reset_n = 1'b1;
      run_chk = 1;
      chk("reset_valid", oValid, 1'b0);
      chk("reset_count", oBypassCount, 4'h0);

      // Preload reg 3 and reg 7 with writes that carry no read.
      step(0, 0, 0, 1, 3, 'h1234, 0);
      step(0, 0, 0, 1, 7, 'h0001, 0);
      idle(2);

      step(1, 3, 5, 0, 0, 0, 0);
      idle(1);
      chk("plain_valid", oValid, 1'b1);
      chk("plain_data0", oData0, 16'h1234);
      chk("plain_hit0", oHit0, 1'b0);
      chk("plain_hit1", oHit1, 1'b0);

      step(1, 5, 5, 1, 5, 'hBEEF, 0);
      idle(1);
      chk("same_data0", oData0, 16'hBEEF);
      chk("same_data1", oData1, 16'hBEEF);
      chk("same_hits", {oHit0, oHit1}, 2'b11);
      idle(1);
      chk("same_count", oBypassCount, 4'h2);

      step(1, 7, 7, 0, 0, 0, 0);
      step(0, 0, 0, 1, 7, 'h00FF, 0);
      chk("next_data0", oData0, 16'h0001);
      chk("next_hit0", oHit0, 1'b0);
      idle(1);

      step(1, 0, 3, 1, 0, 'hAAAA, 0);
      idle(1);
`ifdef REGFILE_BYPASS_ZERO_REG_EN
      chk("zero_data0", oData0, 16'h0000);
      chk("zero_hit0", oHit0, 1'b0);
`else
      chk("zero_data0", oData0, 16'hAAAA);
      chk("zero_hit0", oHit0, 1'b1);
`endif
      idle(1);

      // Back-to-back mix of hits, misses and read-after-write chains.
      for (int i = 0; i < 12; i++)
         step(1, (i * 3) % 16, (i * 5 + 1) % 16, i % 3 != 2, (i * 3 + (i % 2)) % 16, 'h1000 + i * 'h111, 0);
      idle(3);

      // Reset with a request in flight.
      step(1, 3, 3, 1, 3, 'h5555, 0);
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_valid", oValid, 1'b0);
      chk("rst_data", {oData0, oData1}, 32'h0);
      chk("rst_hits", {oHit0, oHit1}, 2'b00);
      chk("rst_count", oBypassCount, 4'h0);
      iReadValid = 0; iWriteEnable = 0; req_v = 0;
      @(posedge Clock);
      #1 Reset_n = 1'b1;
      idle(2);
      chk("rst_novalid", oValid, 1'b0);

      // Counter: 7 double hits plus 1 single hit reaches 15, then saturates.
      for (int i = 0; i < 7; i++) step(1, 9, 9, 1, 9, i, 0);
      step(1, 9, 10, 1, 9, 'h77, 0);
      idle(3);
      chk("cnt_full", oBypassCount, 4'hF);
      step(1, 9, 10, 1, 9, 'h78, 0);
      idle(3);
      chk("cnt_sat", oBypassCount, 4'hF);
      step(1, 2, 3, 1, 2, 'h42, 0);
      idle(1);
      chk("clr_hit_visible", oHit0, 1'b1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("cnt_clear", oBypassCount, 4'h0);
      idle(2);
      chk("cnt_after_clear", oBypassCount, 4'h0);

      run_chk = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
